// File: rtl/seq_array_multiplier_if.sv
`default_nettype none
// ============================================================================
// Module      : seq_array_multiplier_if
// Description : Operand/result handshake bundle for seq_array_multiplier.
//               The master side issues operands and consumes products.
// Revision    : 1.0 - initial release
// ============================================================================
interface seq_array_multiplier_if #(
    parameter int WIDTH = 4
) ();
    logic                 in_valid;
    logic                 in_ready;
    logic                 mode_signed;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic                 out_valid;
    logic                 out_ready;
    logic [2*WIDTH-1:0]   product;
    logic                 busy;

    modport master (
        output in_valid, mode_signed, a, b, out_ready,
        input  in_ready, out_valid, product, busy
    );

    modport slave (
        input  in_valid, mode_signed, a, b, out_ready,
        output in_ready, out_valid, product, busy
    );
endinterface
`default_nettype wire

// File: rtl/seq_array_multiplier.sv
`default_nettype none
// ============================================================================
// Module      : seq_array_multiplier
// Description : Iterative shift-add multiplier, WIDTH x WIDTH -> 2*WIDTH,
//               signed or unsigned, one adder row reused over WIDTH cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_array_multiplier #(
    parameter int WIDTH = 4,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    seq_array_multiplier_if.slave bus
);

    localparam int PW = 2 * WIDTH;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state_q,   state_d;
    logic [CNT_W-1:0]   cnt_q,     cnt_d;
    logic [PW-1:0]      acc_q,     acc_d;
    logic [PW-1:0]      mcand_q,   mcand_d;
    logic [WIDTH-1:0]   mplier_q,  mplier_d;
    logic               neg_q,     neg_d;
    logic [PW-1:0]      product_q, product_d;

    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;
    logic [PW-1:0]      addend;
    logic [PW-1:0]      acc_sum;
    logic [PW-1:0]      acc_step;

    // Next-state, datapath step and operand capture.
    // A negative result is built by accumulating the negated partial
    // products directly, so the single adder row also yields the final
    // two's-complement value without a separate negation stage.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        neg_d     = neg_q;
        product_d = product_q;

        // |-2^(WIDTH-1)| wraps to 2^(WIDTH-1), which is exact as unsigned.
        mag_a = bus.a;
        mag_b = bus.b;
        if (bus.mode_signed && bus.a[WIDTH-1]) begin
            mag_a = ~bus.a + WIDTH'(1);
        end
        if (bus.mode_signed && bus.b[WIDTH-1]) begin
            mag_b = ~bus.b + WIDTH'(1);
        end

        addend   = neg_q ? ~mcand_q : mcand_q;
        acc_sum  = acc_q + addend + PW'(neg_q);
        acc_step = mplier_q[0] ? acc_sum : acc_q;

        case (state_q)
            S_IDLE: begin
                if (bus.in_valid) begin
                    mcand_d  = {{WIDTH{1'b0}}, mag_a};
                    mplier_d = mag_b;
                    neg_d    = bus.mode_signed & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
                    acc_d    = '0;
                    cnt_d    = CNT_W'(WIDTH);
                    state_d  = S_BUSY;
                end
            end
            S_BUSY: begin
                acc_d    = acc_step;
                mplier_d = mplier_q >> 1;
                mcand_d  = mcand_q << 1;
                cnt_d    = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    product_d = acc_step;
                    state_d   = S_DONE;
                end
            end
            S_DONE: begin
                if (bus.out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset also aborts an operation in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            neg_q     <= 1'b0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            neg_q     <= neg_d;
            product_q <= product_d;
        end
    end

    assign bus.in_ready  = (state_q == S_IDLE);
    assign bus.out_valid = (state_q == S_DONE);
    assign bus.busy      = (state_q != S_IDLE);
    assign bus.product   = product_q;

endmodule
`default_nettype wire

// File: tb/tb_seq_array_multiplier.sv
`default_nettype none
// ============================================================================
// Module      : tb_seq_array_multiplier
// Description : Scoreboard bench for seq_array_multiplier at WIDTH=4 and 8.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_array_multiplier;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    seq_array_multiplier_if #(.WIDTH(4)) bus4 ();
    seq_array_multiplier_if #(.WIDTH(8)) bus8 ();

    seq_array_multiplier #(.WIDTH(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));
    seq_array_multiplier #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));

    int n_pass  = 0;
    int n_total = 0;

    logic [7:0]  exp4 [$];
    logic [15:0] exp8 [$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%0h required 0x%0h", nm, act, req);
    endtask

    // Monitors: compare every product handshake against the scoreboard.
    always @(negedge clk) begin
        if (rst_n && bus4.out_valid && bus4.out_ready) begin
            if (exp4.size() == 0) chk("unexpected_out4", 32'(bus4.out_valid), 32'd0);
            else chk("product4", 32'(bus4.product), 32'(exp4.pop_front()));
        end
        if (rst_n && bus8.out_valid && bus8.out_ready) begin
            if (exp8.size() == 0) chk("unexpected_out8", 32'(bus8.out_valid), 32'd0);
            else chk("product8", 32'(bus8.product), 32'(exp8.pop_front()));
        end
    end

    // Present one operation and return right after the accepting edge.
    task automatic issue4(input logic ms, input logic [3:0] a, input logic [3:0] b,
                          input logic [7:0] e);
        int g = 0;
        bus4.mode_signed = ms; bus4.a = a; bus4.b = b; bus4.in_valid = 1'b1;
        while (!bus4.in_ready && g < 100) begin @(posedge clk); #1; g++; end
        if (!bus4.in_ready) begin
            chk("issue4_timeout", 32'(bus4.in_ready), 32'd1);
            bus4.in_valid = 1'b0;
            return;
        end
        exp4.push_back(e);
        @(posedge clk); #1;
        bus4.in_valid = 1'b0;
    endtask

    task automatic issue8(input logic ms, input logic [7:0] a, input logic [7:0] b,
                          input logic [15:0] e);
        int g = 0;
        bus8.mode_signed = ms; bus8.a = a; bus8.b = b; bus8.in_valid = 1'b1;
        while (!bus8.in_ready && g < 200) begin @(posedge clk); #1; g++; end
        if (!bus8.in_ready) begin
            chk("issue8_timeout", 32'(bus8.in_ready), 32'd1);
            bus8.in_valid = 1'b0;
            return;
        end
        exp8.push_back(e);
        @(posedge clk); #1;
        bus8.in_valid = 1'b0;
    endtask

    // Cycles from the accept cycle (counted as 1) until out_valid is seen.
    task automatic wait_valid4(output int k);
        k = 1;
        while (!bus4.out_valid && k < 50) begin @(posedge clk); #1; k++; end
    endtask

    task automatic wait_valid8(output int k);
        k = 1;
        while (!bus8.out_valid && k < 50) begin @(posedge clk); #1; k++; end
    endtask

    function automatic logic [15:0] ref8(input logic ms, input logic [7:0] a,
                                         input logic [7:0] b);
        logic signed [15:0] sa, sb;
        logic [15:0] ua, ub;
        sa = {{8{a[7]}}, a}; sb = {{8{b[7]}}, b};
        ua = {8'h00, a};     ub = {8'h00, b};
        return ms ? 16'(sa * sb) : 16'(ua * ub);
    endfunction

    initial begin
        int lat;
        int g;
        bit rnd_done;
        logic ms_r;
        logic [7:0] a_r, b_r;

        rst_n = 1'b0;
        bus4.in_valid = 1'b0; bus4.mode_signed = 1'b0; bus4.a = '0; bus4.b = '0;
        bus4.out_ready = 1'b1;
        bus8.in_valid = 1'b0; bus8.mode_signed = 1'b0; bus8.a = '0; bus8.b = '0;
        bus8.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", 32'(bus4.in_ready), 32'd1);
        chk("rst_out_valid", 32'(bus4.out_valid), 32'd0);
        chk("rst_busy", 32'(bus4.busy), 32'd0);
        chk("rst_product", 32'(bus4.product), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // 15*15 unsigned with latency and return to IDLE.
        issue4(1'b0, 4'd15, 4'd15, 8'hE1);
        chk("busy_after_accept", 32'(bus4.busy), 32'd1);
        wait_valid4(lat);
        chk("latency4", 32'(lat), 32'd5);
        @(posedge clk); #1;
        chk("idle_in_ready", 32'(bus4.in_ready), 32'd1);
        chk("idle_product_kept", 32'(bus4.product), 32'hE1);

        // Signed cases and zero operands.
        issue4(1'b1, 4'h8, 4'h8, 8'h40); wait_valid4(lat); chk("latency4_s", 32'(lat), 32'd5);
        issue4(1'b1, 4'h8, 4'h7, 8'hC8);
        issue4(1'b1, 4'h3, 4'hF, 8'hFD);
        issue4(1'b0, 4'h0, 4'h9, 8'h00);
        issue4(1'b1, 4'hB, 4'h0, 8'h00);
        issue4(1'b0, 4'hF, 4'h8, 8'h78);
        wait_valid4(lat);
        @(posedge clk); #1;

        // Backpressure: result held, inputs ignored.
        bus4.out_ready = 1'b0;
        issue4(1'b1, 4'h8, 4'h7, 8'hC8);
        wait_valid4(lat);
        for (int i = 0; i < 10; i++) begin
            chk("bp_out_valid", 32'(bus4.out_valid), 32'd1);
            chk("bp_product", 32'(bus4.product), 32'hC8);
            chk("bp_in_ready", 32'(bus4.in_ready), 32'd0);
            bus4.in_valid = 1'b1; bus4.a = 4'h1; bus4.b = 4'h1; bus4.mode_signed = 1'b0;
            @(posedge clk); #1;
        end
        bus4.in_valid = 1'b0;
        bus4.out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_release_out_valid", 32'(bus4.out_valid), 32'd0);
        chk("bp_release_in_ready", 32'(bus4.in_ready), 32'd1);
        chk("bp_release_product", 32'(bus4.product), 32'hC8);

        // Abort in the second BUSY cycle; nothing is pushed for it.
        bus4.mode_signed = 1'b0; bus4.a = 4'd7; bus4.b = 4'd5; bus4.in_valid = 1'b1;
        @(posedge clk); #1;
        bus4.in_valid = 1'b0;
        chk("abort_busy", 32'(bus4.busy), 32'd1);
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("abort_out_valid", 32'(bus4.out_valid), 32'd0);
        chk("abort_product", 32'(bus4.product), 32'd0);
        chk("abort_in_ready", 32'(bus4.in_ready), 32'd1);
        repeat (8) @(posedge clk);
        #1;
        chk("abort_no_result", 32'(bus4.out_valid), 32'd0);
        issue4(1'b0, 4'd7, 4'd5, 8'd35);
        wait_valid4(lat);
        chk("latency4_after_abort", 32'(lat), 32'd5);
        @(posedge clk); #1;

        // WIDTH=8 corner cases.
        issue8(1'b0, 8'hFF, 8'hFF, 16'hFE01);
        wait_valid8(lat);
        chk("latency8", 32'(lat), 32'd9);
        issue8(1'b1, 8'h80, 8'h80, 16'h4000);
        issue8(1'b1, 8'h80, 8'h7F, 16'hC080);
        issue8(1'b1, 8'hFF, 8'hFF, 16'h0001);

        // Random back-to-back traffic with random consumer stalls.
        rnd_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 500; i++) begin
                    ms_r = 1'($urandom_range(0, 1));
                    a_r  = 8'($urandom);
                    b_r  = 8'($urandom);
                    issue8(ms_r, a_r, b_r, ref8(ms_r, a_r, b_r));
                end
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    @(posedge clk); #1;
                    bus8.out_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        bus8.out_ready = 1'b1;

        g = 0;
        while ((exp4.size() != 0 || exp8.size() != 0) && g < 1000) begin
            @(posedge clk); g++;
        end
        chk("drain4", 32'(exp4.size()), 32'd0);
        chk("drain8", 32'(exp8.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d passed", n_pass, n_total);
        $fatal(1);
    end

endmodule
`default_nettype wire
